// File: rtl/mp_pkg.sv
// Shared definitions for the mini-processor host: register map, FSM encoding and defaults.
package mp_pkg;

  localparam logic [15:0] OffOpa    = 16'h0000;
  localparam logic [15:0] OffOpb    = 16'h0001;
  localparam logic [15:0] OffStart  = 16'h0002;
  localparam logic [15:0] OffClear  = 16'h0003;
  localparam logic [15:0] OffResult = 16'h0004;

  localparam int unsigned TimeoutDefault = 1023;
  localparam int unsigned CntWidth       = 16;

  typedef enum logic [3:0] {
    StIdle,
    StReq,
    StWrA,
    StWrB,
    StWrGo,
    StWaitIrq,
    StReqRd,
    StRd,
    StRdWait,
    StWrClr,
    StResp
  } state_e;

  function automatic logic [15:0] reg_addr(input logic [15:0] base, input logic [15:0] off);
    return base + off;
  endfunction

endpackage

// File: rtl/mp_host_if.sv
// Command/response handshakes plus the arbitrated register bus of the mini-processor host.
interface mp_host_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic        rsp_error;
  logic        m_req;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [31:0] m_dout;
  logic        m_grant;
  logic [63:0] m_din;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, rsp_ready, m_grant, m_din,
    output cmd_ready, rsp_valid, rsp_result, rsp_error, m_req, m_wr, m_addr, m_dout
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, rsp_ready, m_grant, m_din,
    input  cmd_ready, rsp_valid, rsp_result, rsp_error, m_req, m_wr, m_addr, m_dout
  );

endinterface

// File: rtl/mp_host_timer.sv
// Interrupt wait counter: cleared on entry to the wait, counts while enabled, flags the last cycle.
module mp_host_timer
  import mp_pkg::*;
#(
  parameter int unsigned Width = CntWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [Width-1:0] limit,
  output logic             expired
);

  logic [Width-1:0] count_q;

  // Expires on the limit-th enabled cycle; a zero limit expires at once.
  assign expired = enable && ((limit == '0) || (count_q >= limit - Width'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + Width'(1);
    end
  end

endmodule

// File: rtl/mp_host.sv
// Bus master that loads two operands into the mini processor, starts it, waits for its
// interrupt (with timeout), reads the 64-bit result, clears the processor and returns a response.
module mp_host
  import mp_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned TIMEOUT   = TimeoutDefault
) (
  input  logic      clk,
  input  logic      reset,
  mp_host_if.master bus,
  input  logic      interrupt_in,
  output logic      busy
);

  state_e      state_q, state_d;
  logic [31:0] opa_q, opb_q;
  logic [63:0] result_q;
  logic        err_q;
  logic        tmr_clear, tmr_en, tmr_expired;

  logic        m_req, m_wr;
  logic [15:0] m_addr;
  logic [31:0] m_dout;

  assign tmr_clear = (state_q == StWrGo) && bus.m_grant;
  assign tmr_en    = (state_q == StWaitIrq);

  mp_host_timer #(
    .Width (CntWidth)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .limit   (CntWidth'(TIMEOUT)),
    .expired (tmr_expired)
  );

  // Every bus state advances only on grant, so a dropped grant repeats the same access.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (bus.cmd_valid) state_d = StReq;
      StReq:     if (bus.m_grant) state_d = err_q ? StWrClr : StWrA;
      StWrA:     if (bus.m_grant) state_d = StWrB;
      StWrB:     if (bus.m_grant) state_d = StWrGo;
      StWrGo:    if (bus.m_grant) state_d = StWaitIrq;
      StWaitIrq: begin
        if (interrupt_in)     state_d = StReqRd;
        else if (tmr_expired) state_d = StReq;
      end
      StReqRd:   if (bus.m_grant) state_d = StRd;
      StRd:      if (bus.m_grant) state_d = StRdWait;
      StRdWait:  state_d = StWrClr;
      StWrClr:   if (bus.m_grant) state_d = StResp;
      StResp:    if (bus.rsp_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    m_req  = 1'b0;
    m_wr   = 1'b0;
    m_addr = '0;
    m_dout = '0;
    case (state_q)
      StReq, StReqRd, StRdWait: m_req = 1'b1;
      StWrA: begin
        m_req  = 1'b1;
        m_wr   = 1'b1;
        m_addr = reg_addr(BASE_ADDR, OffOpa);
        m_dout = opa_q;
      end
      StWrB: begin
        m_req  = 1'b1;
        m_wr   = 1'b1;
        m_addr = reg_addr(BASE_ADDR, OffOpb);
        m_dout = opb_q;
      end
      StWrGo: begin
        m_req  = 1'b1;
        m_wr   = 1'b1;
        m_addr = reg_addr(BASE_ADDR, OffStart);
        m_dout = 32'h1;
      end
      StRd: begin
        m_req  = 1'b1;
        m_addr = reg_addr(BASE_ADDR, OffResult);
      end
      StWrClr: begin
        m_req  = 1'b1;
        m_wr   = 1'b1;
        m_addr = reg_addr(BASE_ADDR, OffClear);
        m_dout = 32'h1;
      end
      default: ;
    endcase
  end

  assign bus.m_req      = m_req;
  assign bus.m_wr       = m_wr;
  assign bus.m_addr     = m_addr;
  assign bus.m_dout     = m_dout;
  assign bus.cmd_ready  = (state_q == StIdle);
  assign bus.rsp_valid  = (state_q == StResp);
  assign bus.rsp_result = result_q;
  assign bus.rsp_error  = err_q;
  assign busy           = (state_q != StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && bus.cmd_valid) begin
        opa_q    <= bus.cmd_a;
        opb_q    <= bus.cmd_b;
        result_q <= '0;
        err_q    <= 1'b0;
      end
      if (state_q == StWaitIrq && !interrupt_in && tmr_expired) begin
        result_q <= '0;
        err_q    <= 1'b1;
      end
      // Read data arrives the cycle after the granted RESULT access.
      if (state_q == StRdWait) begin
        result_q <= bus.m_din;
      end
    end
  end

endmodule

// File: tb/tb_mp_host.sv
// Directed bench for mp_host: bus slave model, grant/interrupt stimulus and response checks.
module tb_mp_host;

  localparam logic [15:0] Base = 16'h0100;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
  } acc_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic interrupt_in = 1'b0;
  logic busy;

  mp_host_if bus ();

  mp_host #(
    .BASE_ADDR (Base),
    .TIMEOUT   (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.master),
    .interrupt_in (interrupt_in),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  acc_t log_q[$];
  logic [63:0] rd_value = '0;
  bit rd_pend = 1'b0;
  bit start_seen = 1'b0;
  int wait_cnt = 0;
  int bus_viol = 0;
  bit gt_en = 1'b0;
  int req_hold = 0;
  int wrb_hold = 0;
  bit req_done = 1'b0;
  bit wrb_done = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Slave model: logs granted accesses and returns read data one cycle after a RESULT read.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_pend) begin
        bus.m_din = rd_value;
        rd_pend   = 1'b0;
      end else begin
        bus.m_din = 64'hdead_beef_dead_beef;
      end
      if (!reset && bus.m_req && bus.m_grant) begin
        if (bus.m_wr) begin
          log_q.push_back({1'b1, bus.m_addr, bus.m_dout});
          if (bus.m_addr == Base + 16'd2) start_seen = 1'b1;
        end else if (bus.m_addr == Base + 16'd4) begin
          log_q.push_back({1'b0, bus.m_addr, 32'h0});
          rd_pend = 1'b1;
        end
      end
      if (busy && !bus.m_req && !bus.rsp_valid) wait_cnt++;
      if (!bus.m_req && (bus.m_wr || bus.m_addr != 16'h0 || bus.m_dout != 32'h0)) bus_viol++;
    end
  end

  // Grant controller: withholds grant 3 cycles in REQ and 2 cycles in WR_B when enabled.
  initial begin
    forever begin
      step();
      if (gt_en) begin
        if (!req_done && busy && bus.m_req && !bus.m_wr && bus.m_addr == 16'h0) begin
          if (req_hold < 3) begin
            bus.m_grant = 1'b0;
            req_hold++;
          end else begin
            bus.m_grant = 1'b1;
            req_done    = 1'b1;
          end
        end else if (!wrb_done && bus.m_wr && bus.m_addr == Base + 16'd1) begin
          if (wrb_hold < 2) begin
            bus.m_grant = 1'b0;
            wrb_hold++;
          end else begin
            bus.m_grant = 1'b1;
            wrb_done    = 1'b1;
          end
        end
      end
    end
  end

  task automatic check_seq(input logic [31:0] a, input logic [31:0] b, input bit tmo);
    acc_t exp_q[$];
    exp_q.push_back({1'b1, Base + 16'd0, a});
    exp_q.push_back({1'b1, Base + 16'd1, b});
    exp_q.push_back({1'b1, Base + 16'd2, 32'h1});
    if (!tmo) exp_q.push_back({1'b0, Base + 16'd4, 32'h0});
    exp_q.push_back({1'b1, Base + 16'd3, 32'h1});
    chk("log_len", 64'(log_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < log_q.size()) chk($sformatf("access%0d", i), 64'(log_q[i]), 64'(exp_q[i]));
    end
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok = 1'b0;
    log_q.delete();
    start_seen  = 1'b0;
    wait_cnt    = 0;
    bus.cmd_a   = a;
    bus.cmd_b   = b;
    bus.cmd_valid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      if (bus.cmd_ready) ok = 1'b1;
      step();
    end
    bus.cmd_valid = 1'b0;
    chk("cmd_accept", 64'(ok), 64'd1);
    ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      if (start_seen) ok = 1'b1;
      else step();
    end
    chk("start_write", 64'(ok), 64'd1);
  endtask

  // irq_dly = 0 means the interrupt never comes.
  task automatic do_cmd(input logic [31:0] a, input logic [31:0] b, input logic [63:0] res,
                        input int irq_dly, input int stall, input bit tmo);
    bit ok;
    rd_value      = res;
    bus.rsp_ready = (stall == 0);
    send_cmd(a, b);
    if (irq_dly > 0) begin
      repeat (irq_dly - 1) step();
      interrupt_in = 1'b1;
    end
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      if (bus.rsp_valid) ok = 1'b1;
      else step();
    end
    interrupt_in = 1'b0;
    chk("rsp_valid", 64'(ok), 64'd1);
    chk("wait_cycles", 64'(wait_cnt), tmo ? 64'd8 : 64'(irq_dly));
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", 64'(bus.rsp_valid), 64'd1);
      chk("stall_result", bus.rsp_result, tmo ? 64'd0 : res);
      chk("stall_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    chk("rsp_result", bus.rsp_result, tmo ? 64'd0 : res);
    chk("rsp_error", 64'(bus.rsp_error), 64'(tmo));
    step();
    chk("rsp_consumed", 64'(bus.rsp_valid), 64'd0);
    chk("ready_after_rsp", 64'(bus.cmd_ready), 64'd1);
    check_seq(a, b, tmo);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b1;
    bus.m_grant   = 1'b1;
    bus.m_din     = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_m_req", 64'(bus.m_req), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_result", bus.rsp_result, 64'd0);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // Interrupt level in IDLE does nothing.
    interrupt_in = 1'b1;
    repeat (3) step();
    chk("idle_irq_busy", 64'(busy), 64'd0);
    chk("idle_irq_req", 64'(bus.m_req), 64'd0);
    interrupt_in = 1'b0;
    step();

    // 7 * 6 = 42, interrupt five cycles after START.
    do_cmd(32'd7, 32'd6, 64'd42, 5, 0, 1'b0);

    // Grant withheld in REQ and dropped during WR_B.
    req_hold = 0; wrb_hold = 0; req_done = 1'b0; wrb_done = 1'b0; gt_en = 1'b1;
    do_cmd(32'h1234_5678, 32'h9abc_def0, 64'h0123_4567_89ab_cdef, 3, 0, 1'b0);
    gt_en = 1'b0;
    bus.m_grant = 1'b1;
    chk("req_hold_cycles", 64'(req_hold), 64'd3);
    chk("wrb_hold_cycles", 64'(wrb_hold), 64'd2);

    // No interrupt: timeout after 8 wait cycles.
    do_cmd(32'd3, 32'd4, 64'd12, 0, 0, 1'b1);

    // Response held off for 4 cycles.
    do_cmd(32'd10, 32'd11, 64'd110, 2, 4, 1'b0);

    // Reset in WAIT_IRQ discards the command.
    send_cmd(32'd5, 32'd5);
    step();
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_m_req", 64'(bus.m_req), 64'd0);
    chk("arst_m_wr", 64'(bus.m_wr), 64'd0);
    chk("arst_m_addr", 64'(bus.m_addr), 64'd0);
    chk("arst_m_dout", 64'(bus.m_dout), 64'd0);
    chk("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("arst_rsp_error", 64'(bus.rsp_error), 64'd0);
    chk("arst_rsp_result", bus.rsp_result, 64'd0);
    step();
    reset = 1'b0;
    repeat (12) step();
    chk("arst_no_rsp", 64'(bus.rsp_valid), 64'd0);
    chk("arst_idle", 64'(busy), 64'd0);
    do_cmd(32'd9, 32'd9, 64'd81, 4, 0, 1'b0);

    // Back-to-back commands, results in order.
    do_cmd(32'd2, 32'd3, 64'd6, 1, 0, 1'b0);
    do_cmd(32'd4, 32'd5, 64'd20, 2, 0, 1'b0);

    chk("idle_bus_quiet", 64'(bus_viol), 64'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
